// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enemy_pkg
// Description : Shared types for the enemy sequencer and the enemy datapath:
//               sequencer state encoding, movement direction codes, counter
//               widths and a small phase-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_pkg;

    // Sequencer states; the numeric encoding is visible to debug tooling.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_GEN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_APPLY = 3'd4,
        ST_REQ   = 3'd5,
        ST_DRAW  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Direction codes understood by single_enemy.
    typedef enum logic [2:0] {
        DIR_UP    = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4,
        DIR_RIGHT = 3'd5
    } dir_t;

    localparam int CNT_W = 4;   // frame divider and CHECK dwell counter
    localparam int WD_W  = 9;   // DRAW watchdog counter

    // The VGA write path is requested from REQ until DRAW finishes.
    function automatic logic holds_vga(input state_t s);
        return (s == ST_REQ) || (s == ST_DRAW);
    endfunction

endpackage : enemy_pkg
`default_nettype wire

// File: rtl/enemy_control.sv
`default_nettype none
// ============================================================================
// Module      : enemy_control
// Description : Per-enemy frame sequencer. Emits one-hot phase strobes to
//               single_enemy, requests the shared VGA path, paces movement
//               against the frame tick and flags overrun / stuck draws.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_control
    import enemy_pkg::*;
#(
    parameter int CHECK_CYCLES = 2,
    parameter int MOVE_DIV     = 2,
    parameter int DRAW_TIMEOUT = 300
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_tick,
    input  logic enable,
    input  logic draw_grant,
    input  logic draw_done,
    output logic init,
    output logic idle,
    output logic gen_move,
    output logic apply_move,
    output logic draw,
    output logic draw_req,
    output logic cycle_done,
    output logic frame_overrun,
    output logic draw_timeout
);

    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FC_LAST  = CNT_W'(MOVE_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DRAW_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             started;     // low only until the first edge after reset
    logic             pending;     // one frame tick waiting to be served
    logic             leave_idle;
    logic             wd_expire;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [WD_W-1:0]  wd_cnt;

    // Next-state decode; also flags the IDLE exit and the watchdog abort.
    always_comb begin
        state_nxt  = state;
        leave_idle = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_INIT:  if (started) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (enable && (frame_tick || pending)) begin
                    leave_idle = 1'b1;
                    state_nxt  = (frame_cnt == '0) ? ST_GEN : ST_REQ;
                end
            end
            ST_GEN:   state_nxt = ST_CHECK;
            ST_CHECK: if (chk_cnt == CHK_LAST) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_REQ;
            ST_REQ:   if (draw_grant) state_nxt = ST_DRAW;
            ST_DRAW: begin
                if (draw_done) begin
                    state_nxt = ST_DONE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // State, counters, sticky flags and strobes registered from next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_INIT;
            started       <= 1'b0;
            pending       <= 1'b0;
            frame_cnt     <= '0;
            chk_cnt       <= '0;
            wd_cnt        <= '0;
            init          <= 1'b0;
            idle          <= 1'b0;
            gen_move      <= 1'b0;
            apply_move    <= 1'b0;
            draw          <= 1'b0;
            draw_req      <= 1'b0;
            cycle_done    <= 1'b0;
            frame_overrun <= 1'b0;
            draw_timeout  <= 1'b0;
        end else begin
            started    <= 1'b1;
            state      <= state_nxt;
            init       <= (state_nxt == ST_INIT);
            idle       <= (state_nxt == ST_IDLE);
            gen_move   <= (state_nxt == ST_GEN);
            apply_move <= (state_nxt == ST_APPLY);
            draw       <= (state_nxt == ST_DRAW);
            draw_req   <= holds_vga(state_nxt);
            cycle_done <= (state_nxt == ST_DONE);

            // Dwell counters restart whenever their state is not occupied.
            chk_cnt <= (state == ST_CHECK) ? chk_cnt + 1'b1 : '0;
            wd_cnt  <= (state == ST_DRAW)  ? wd_cnt + 1'b1  : '0;

            // A tick on the IDLE exit cycle is absorbed by that exit.
            if (leave_idle) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                pending   <= 1'b0;
            end else if (frame_tick && (state != ST_IDLE)) begin
                if (pending) frame_overrun <= 1'b1;
                else         pending       <= 1'b1;
            end

            if (wd_expire) draw_timeout <= 1'b1;
        end
    end

endmodule : enemy_control
`default_nettype wire

// File: tb/tb_enemy_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_control
// Description : Self-checking bench for enemy_control. Each frame is planned
//               as a schedule of absolute cycle numbers; the expected event
//               times are queued and a monitor compares observed events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_control;

    localparam int CC = 2;
    localparam int MD = 2;
    localparam int DT = 300;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0;
    logic enable = 1'b1;
    logic draw_grant = 1'b0;
    logic draw_done = 1'b0;
    logic init, idle, gen_move, apply_move, draw, draw_req, cycle_done;
    logic frame_overrun, draw_timeout;

    enemy_control #(
        .CHECK_CYCLES (CC),
        .MOVE_DIV     (MD),
        .DRAW_TIMEOUT (DT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .enable        (enable),
        .draw_grant    (draw_grant),
        .draw_done     (draw_done),
        .init          (init),
        .idle          (idle),
        .gen_move      (gen_move),
        .apply_move    (apply_move),
        .draw          (draw),
        .draw_req      (draw_req),
        .cycle_done    (cycle_done),
        .frame_overrun (frame_overrun),
        .draw_timeout  (draw_timeout)
    );

    always #5 clock = ~clock;

    // Cycle number: cycle 1 is the interval after the first edge out of reset.
    int cyc;
    always @(posedge clock or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    logic [8:0] ov;
    assign ov = {init, idle, gen_move, apply_move, draw, draw_req,
                 cycle_done, frame_overrun, draw_timeout};

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected event times of one frame.
    typedef struct {
        bit mv;
        int gen;
        int apl;
        int req;
        int ds;
        int dlen;
        int dn;
        bit ovr;
        bit to;
    } rec_t;
    rec_t q[$];

    // Input schedule, in absolute cycles.
    int tk_a = -1, tk_b = -1, tk_c = -1;
    int gr_lo = -1, gr_hi = -2;
    int dd_lo = -1, dd_hi = -2;
    int en_lo = -1, en_hi = -2;

    // Model state.
    int last_end   = 0;
    int pend_start = -1;
    int fc_model   = 0;
    bit ovr_exp    = 1'b0;
    bit to_exp     = 1'b0;

    task automatic advance_to(input int c_end);
        while (cyc < c_end) begin
            @(posedge clock);
            #1;
            frame_tick = (cyc == tk_a) || (cyc == tk_b) || (cyc == tk_c);
            draw_grant = (cyc >= gr_lo) && (cyc <= gr_hi);
            draw_done  = (cyc >= dd_lo) && (cyc <= dd_hi);
            enable     = !((cyc >= en_lo) && (cyc <= en_hi));
        end
    endtask

    // One frame: gap before the tick, grant delay, draw_done delay into DRAW
    // (-1 = never), extra ticks during DRAW, and an optional enable hold-off.
    task automatic frame(input int gap, input int gd, input int dd,
                         input int ex, input bit hold, input int hl);
        int t, s, req, g, ds, d, dn;
        bit mv;
        rec_t r;
        if (pend_start >= 0) begin
            s    = pend_start;
            tk_a = -1;
        end else begin
            t    = last_end + 1 + gap;
            tk_a = t;
            s    = t + 1;
        end
        mv       = (fc_model == 0);
        fc_model = (fc_model + 1) % MD;
        req      = mv ? s + 2 + CC : s;
        g        = req + gd;
        ds       = g + 1;
        if (dd >= 0) begin
            d  = ds + dd;
            dn = d + 1;
        end else begin
            d      = -1;
            dn     = ds + DT;
            to_exp = 1'b1;
        end
        tk_b = (ex >= 1) ? ds + 1 : -1;
        tk_c = (ex >= 2) ? ds + 2 : -1;
        if (ex >= 2) ovr_exp = 1'b1;
        gr_lo = g;
        gr_hi = dn - 1;
        dd_lo = (d >= 0) ? d : -1;
        dd_hi = (d >= 0) ? dn - 1 : -2;
        if (ex >= 1 && hold) begin
            en_lo      = ds;
            en_hi      = dn + hl;
            pend_start = dn + hl + 2;
        end else begin
            en_lo      = -1;
            en_hi      = -2;
            pend_start = (ex >= 1) ? dn + 2 : -1;
        end
        r = '{mv, s, s + 1 + CC, req, ds, dn - ds, dn, ovr_exp, to_exp};
        q.push_back(r);
        if (ex >= 1 && hold) begin
            advance_to(dn + hl + 1);
            last_end = dn + hl + 1;
        end else begin
            advance_to(dn);
            last_end = dn;
        end
    endtask

    // Monitor: gathers observed event times and scores them at cycle_done.
    bit mon_en = 1'b0;
    int a_gen = -1, a_apl = -1, a_req = -1, a_ds = -1, a_dlen = 0;
    int onehot_err = 0;
    always @(negedge clock) begin
        rec_t r;
        if (mon_en) begin
            if (int'(init) + int'(idle) + int'(gen_move) + int'(apply_move) + int'(draw) > 1)
                onehot_err++;
            if (gen_move   && a_gen < 0) a_gen = cyc;
            if (apply_move && a_apl < 0) a_apl = cyc;
            if (draw_req   && a_req < 0) a_req = cyc;
            if (draw       && a_ds  < 0) a_ds  = cyc;
            if (draw) a_dlen++;
            if (cycle_done) begin
                if (q.size() == 0) begin
                    check("spurious_cycle_done", 1, 0);
                end else begin
                    r = q.pop_front();
                    check("gen_move_cycle",   a_gen, r.mv ? r.gen : -1);
                    check("apply_move_cycle", a_apl, r.mv ? r.apl : -1);
                    check("draw_req_start",   a_req, r.req);
                    check("draw_start",       a_ds,  r.ds);
                    check("draw_length",      a_dlen, r.dlen);
                    check("cycle_done_cycle", cyc,   r.dn);
                    check("frame_overrun",    int'(frame_overrun), int'(r.ovr));
                    check("draw_timeout",     int'(draw_timeout),  int'(r.to));
                end
                a_gen = -1; a_apl = -1; a_req = -1; a_ds = -1; a_dlen = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int gp, gd, dd, ex, hl;
        bit hd;

        // Reset state and the release sequence.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", int'(ov), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("cycle1_init", int'(ov), 9'h100);
        @(posedge clock);
        #1;
        check("cycle2_idle", int'(ov), 9'h080);
        mon_en   = 1'b1;
        last_end = cyc;

        frame(7, 0, 256, 0, 1'b0, 0);   // move frame, tick at cycle 10
        frame(3, 0, 20,  0, 1'b0, 0);   // redraw-only frame
        frame(2, 50, 10, 0, 1'b0, 0);   // grant withheld 50 cycles
        frame(1, 2, 5,   2, 1'b0, 0);   // two ticks during DRAW
        frame(0, 1, 8,   0, 1'b0, 0);   // served from pending
        frame(2, 0, -1,  0, 1'b0, 0);   // watchdog abort

        // Ticks while disabled in IDLE are dropped.
        en_lo = last_end + 1;
        en_hi = last_end + 12;
        tk_a  = last_end + 2;
        tk_b  = last_end + 5;
        tk_c  = last_end + 9;
        advance_to(last_end + 13);
        last_end = last_end + 13;
        check("disabled_no_req", a_req, -1);
        check("disabled_no_gen", a_gen, -1);
        check("disabled_idle",   int'(idle), 1);

        frame(1, 1, 6, 1, 1'b1, 4);     // enable drops mid-frame with pending
        frame(0, 0, 4, 0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            gp = $urandom_range(0, 4);
            gd = $urandom_range(0, 8);
            dd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(3, 40));
            ex = $urandom_range(0, 2);
            hd = (ex > 0) && ($urandom_range(0, 2) == 0);
            hl = $urandom_range(0, 5);
            frame(gp, gd, dd, ex, hd, hl);
        end
        frame(1, 0, 5, 0, 1'b0, 0);
        if (fc_model != 0) frame(1, 0, 5, 0, 1'b0, 0);

        @(negedge clock);
        #1;
        check("queue_drained", q.size(), 0);
        check("onehot_violations", onehot_err, 0);

        // Asynchronous reset while APPLY is being shown.
        mon_en = 1'b0;
        tk_a   = last_end + 2;
        advance_to(last_end + 2 + 1 + 1 + CC);
        check("apply_before_reset", int'(apply_move), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", int'(ov), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_init", int'(ov), 9'h100);
        @(posedge clock);
        #1;
        check("post_reset_idle", int'(ov), 9'h080);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_enemy_control
`default_nettype wire
